// File: rtl/cu_step_sequencer.sv
// ---------------------------------------------------------------------------
// cu_step_sequencer
//   Control-unit step clock. Generates the one-hot T-step (within an M-cycle)
//   and M-count (within an opcode) strobes, the IR-read slot, the
//   fetch-initialise flag, HALT sleep/wake and the interrupt-dispatch request.
//
// Parameters
//   T_PER_M  T-cycles per M-cycle (power of two, >= 2)
//   MAX_M    maximum M-cycles per opcode (power of two, >= 2)
//   NUM_IRQ  interrupt request lines (<= 8)
//
// Optional feature macro: CU_WATCHDOG_EN
//   When defined, a counter overflow latches a sticky fault that parks the
//   sequencer at step 0 until i_Rst. When undefined, o_Fault is tied low.
//
// Ports
//   i_Clk, i_Rst          clock, synchronous active-high reset
//   i_Enable              clock enable; nothing changes while low
//   i_Reset_Cycle         end-of-opcode request (next step is 0)
//   i_Halt                HALT request
//   i_IME, i_Interrupts   master enable and IE-masked pending lines
//   o_IR_Read             step-0 IR-read slot
//   o_T_Step, o_M_Count   one-hot strobes (all zero in step 0)
//   o_Initialize_Fetch    fetch microcode owns the current M-cycle
//   o_Halted              core sleeping in HALT
//   o_Handle_Interrupt    dispatch request (combinational)
//   o_Irq_Index           lowest-numbered pending line
//   o_Wrap                one-cycle overflow pulse
//   o_Fault               sticky watchdog fault
// ---------------------------------------------------------------------------
module cu_step_sequencer #(
  parameter int T_PER_M = 4,
  parameter int MAX_M   = 8,
  parameter int NUM_IRQ = 5
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Enable,
  input  logic               i_Reset_Cycle,
  input  logic               i_Halt,
  input  logic               i_IME,
  input  logic [NUM_IRQ-1:0] i_Interrupts,
  output logic               o_IR_Read,
  output logic [T_PER_M-1:0] o_T_Step,
  output logic [MAX_M-1:0]   o_M_Count,
  output logic               o_Initialize_Fetch,
  output logic               o_Halted,
  output logic               o_Handle_Interrupt,
  output logic [2:0]         o_Irq_Index,
  output logic               o_Wrap,
  output logic               o_Fault
);

  localparam int STEPS = T_PER_M * MAX_M;
  localparam int SW    = $clog2(STEPS);
  localparam int TW    = $clog2(T_PER_M);

  logic [SW-1:0]      r_Step;
  logic               r_Init_Fetch;
  logic               r_Halted;
  logic               r_Wrap;

  logic               w_Pending;
  logic               w_At_Max;
  logic               w_Halt_Loop;
  logic               w_Fault;
  logic               w_Step_Zero;
  logic [TW-1:0]      w_T_Idx;
  logic [SW-TW-1:0]   w_M_Idx;
  logic [2:0]         w_Irq_Index;

  assign w_Pending   = |i_Interrupts;
  assign w_At_Max    = (r_Step == SW'(STEPS - 1));
  // A sleeping core only ever replays the first M-cycle.
  assign w_Halt_Loop = r_Halted && (r_Step == SW'(T_PER_M - 1));
  assign w_Step_Zero = (r_Step == '0);
  assign w_T_Idx     = r_Step[TW-1:0];
  assign w_M_Idx     = r_Step[SW-1:TW];

`ifdef CU_WATCHDOG_EN
  logic r_Fault;
  assign w_Fault = r_Fault;
`else
  assign w_Fault = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Step       <= '0;
      r_Init_Fetch <= 1'b1;
      r_Halted     <= 1'b0;
      r_Wrap       <= 1'b0;
`ifdef CU_WATCHDOG_EN
      r_Fault      <= 1'b0;
`endif
    end else if (i_Enable) begin
      r_Wrap <= 1'b0;
      if (w_Fault) begin
        // Parked: all requests ignored until reset.
        r_Step       <= '0;
        r_Init_Fetch <= 1'b1;
      end else begin
        if (i_Reset_Cycle) begin
          r_Step       <= '0;
          r_Init_Fetch <= 1'b0;
        end else if (w_Halt_Loop) begin
          r_Step <= '0;
        end else if (w_At_Max) begin
          r_Step <= '0;
          r_Wrap <= 1'b1;
`ifdef CU_WATCHDOG_EN
          r_Fault      <= 1'b1;
          r_Init_Fetch <= 1'b1;
`endif
        end else begin
          r_Step <= r_Step + 1'b1;
        end
        // Wake beats halt; HALT with a pending line never sleeps. Halt also
        // wins the fetch flag over an end-of-opcode on the same edge, since
        // HALT is normally issued together with i_Reset_Cycle.
        if (w_Pending) begin
          r_Halted <= 1'b0;
        end else if (i_Halt) begin
          r_Halted     <= 1'b1;
          r_Init_Fetch <= 1'b1;
        end
      end
    end else begin
      r_Wrap <= 1'b0;
    end
  end

  // Lowest-numbered pending line wins; scan from the top so bit 0 overrides.
  always_comb begin
    w_Irq_Index = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_Interrupts[i]) w_Irq_Index = 3'(i);
    end
  end

  assign o_IR_Read          = w_Step_Zero;
  assign o_T_Step           = w_Step_Zero ? '0 : ({{(T_PER_M-1){1'b0}}, 1'b1} << w_T_Idx);
  assign o_M_Count          = w_Step_Zero ? '0 : ({{(MAX_M-1){1'b0}}, 1'b1} << w_M_Idx);
  assign o_Initialize_Fetch = r_Init_Fetch;
  assign o_Halted           = r_Halted;
  assign o_Handle_Interrupt = i_Reset_Cycle & i_IME & w_Pending & ~r_Halted & ~w_Fault;
  assign o_Irq_Index        = w_Irq_Index;
  assign o_Wrap             = r_Wrap;
  assign o_Fault            = w_Fault;

endmodule

// File: tb/tb_cu_step_sequencer.sv
// Directed bench for cu_step_sequencer: default-parameter instance exercising
// step decode, end-of-opcode, HALT sleep/wake, interrupt dispatch and wrap,
// plus a T_PER_M=8 / MAX_M=4 instance for the alternate decode.
module tb_cu_step_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, rc, halt, ime;
  logic [4:0] irq;

  logic       ir, ifetch, halted, dispatch, wrap, fault;
  logic [3:0] tstep;
  logic [7:0] mcnt;
  logic [2:0] idx;

  logic       b_ir, b_if, b_halted, b_dispatch, b_wrap, b_fault;
  logic [7:0] b_tstep;
  logic [3:0] b_mcnt;
  logic [2:0] b_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cu_step_sequencer dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Reset_Cycle(rc),
    .i_Halt(halt), .i_IME(ime), .i_Interrupts(irq),
    .o_IR_Read(ir), .o_T_Step(tstep), .o_M_Count(mcnt),
    .o_Initialize_Fetch(ifetch), .o_Halted(halted),
    .o_Handle_Interrupt(dispatch), .o_Irq_Index(idx),
    .o_Wrap(wrap), .o_Fault(fault)
  );

  cu_step_sequencer #(.T_PER_M(8), .MAX_M(4), .NUM_IRQ(5)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Reset_Cycle(1'b0),
    .i_Halt(1'b0), .i_IME(1'b0), .i_Interrupts(5'b0),
    .o_IR_Read(b_ir), .o_T_Step(b_tstep), .o_M_Count(b_mcnt),
    .o_Initialize_Fetch(b_if), .o_Halted(b_halted),
    .o_Handle_Interrupt(b_dispatch), .o_Irq_Index(b_idx),
    .o_Wrap(b_wrap), .o_Fault(b_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; rc = 1'b0; halt = 1'b0; ime = 1'b0; irq = 5'b0;
    step();
    rst = 1'b0;
    // Reset state, s=0
    check("rst_ir",     ir,       1);
    check("rst_tstep",  tstep,    0);
    check("rst_mcnt",   mcnt,     0);
    check("rst_if",     ifetch,   1);
    check("rst_halted", halted,   0);
    check("rst_disp",   dispatch, 0);
    check("rst_idx",    idx,      0);
    check("rst_wrap",   wrap,     0);
    check("rst_fault",  fault,    0);

    // Free run: s=1..4
    step();
    check("s1_ir",    ir,    0);
    check("s1_tstep", tstep, 4'b0010);
    check("s1_mcnt",  mcnt,  8'b00000001);
    step(3);
    check("s4_tstep", tstep, 4'b0001);
    check("s4_mcnt",  mcnt,  8'b00000010);
    check("s4_ir",    ir,    0);

    // To s=7, end-of-opcode blocked by enable low, then accepted
    step(3);
    check("s7_tstep", tstep, 4'b1000);
    rc = 1'b1; en = 1'b0;
    step();
    check("hold_tstep", tstep, 4'b1000);
    check("hold_mcnt",  mcnt,  8'b00000010);
    check("hold_if",    ifetch, 1);
    en = 1'b1;
    step();
    rc = 1'b0;
    check("rc_ir", ir,     1);
    check("rc_if", ifetch, 0);

    // HALT at s=3 (issued with end-of-opcode)
    step(3);
    check("h_s3_tstep", tstep, 4'b1000);
    halt = 1'b1; rc = 1'b1;
    step();
    halt = 1'b0; rc = 1'b0;
    check("halt_set", halted, 1);
    check("halt_if",  ifetch, 1);
    check("halt_ir",  ir,     1);
    step(3);
    check("loop_s3_tstep", tstep, 4'b1000);
    check("loop_s3_mcnt",  mcnt,  8'b00000001);
    step();
    check("loop_back_ir", ir, 1);
    // Pending line while sleeping: no dispatch, wake next edge
    irq = 5'b00100; ime = 1'b1; rc = 1'b1;
    #1;
    check("sleep_disp", dispatch, 0);
    check("sleep_idx",  idx,      2);
    rc = 1'b0;
    step();
    check("wake", halted, 0);
    irq = 5'b0;

    // Interrupt dispatch
    rc = 1'b1; ime = 1'b1; irq = 5'b10110;
    #1;
    check("dispatch_req", dispatch, 1);
    check("dispatch_idx", idx,      1);
    ime = 1'b0;
    #1;
    check("no_ime_disp", dispatch, 0);
    ime = 1'b1; irq = 5'b0;
    #1;
    check("no_irq_disp", dispatch, 0);
    check("no_irq_idx",  idx,      0);
    irq = 5'b10000;
    #1;
    check("irq4_idx", idx, 4);
    // HALT with a pending line does not sleep
    halt = 1'b1;
    step();
    halt = 1'b0; rc = 1'b0; irq = 5'b0; ime = 1'b0;
    check("halt_pend_nosleep", halted, 0);
    check("after_rc_ir", ir, 1);

    // Overflow from s=0 through s=31
    step(31);
    check("s31_tstep", tstep, 4'b1000);
    check("s31_mcnt",  mcnt,  8'b10000000);
    check("s31_wrap",  wrap,  0);
    step();
    check("wrap_pulse", wrap, 1);
    check("wrap_ir",    ir,   1);
`ifdef CU_WATCHDOG_EN
    check("wd_fault", fault,  1);
    check("wd_if",    ifetch, 1);
    rc = 1'b1; ime = 1'b1; irq = 5'b00001; halt = 1'b1;
    #1;
    check("wd_disp", dispatch, 0);
    step();
    rc = 1'b0; ime = 1'b0; irq = 5'b0; halt = 1'b0;
    check("wd_hold_ir",   ir,     1);
    check("wd_wrap_once", wrap,   0);
    check("wd_sticky",    fault,  1);
    check("wd_nohalt",    halted, 0);
    step(3);
    check("wd_still_s0", ir, 1);
`else
    check("nowd_fault", fault, 0);
    step();
    check("wrap_once", wrap,  0);
    check("post_wrap", tstep, 4'b0010);
`endif

    // Alternate geometry: T_PER_M=8, MAX_M=4
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_clear_fault", fault, 0);
    check("b_rst_ir", b_ir, 1);
    step(9);
    check("b_s9_tstep", b_tstep, 8'b00000010);
    check("b_s9_mcnt",  b_mcnt,  4'b0010);
    step(22);
    check("b_s31_tstep", b_tstep, 8'b10000000);
    check("b_s31_mcnt",  b_mcnt,  4'b1000);
    step();
    check("b_wrap", b_wrap, 1);
    check("b_wrap_ir", b_ir, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_step_sequencer.md
Name: cu_step_sequencer

Overview:
- Parametrised successor to the control unit's step clock, halt and fetch-initialise logic.
- Generates the one-hot T-step (within an M-cycle) and M-count (within an opcode) strobes for the microcode blocks.
- Owns the IR-read slot, the fetch-initialise flag, HALT sleep/wake and interrupt-dispatch request, with configurable T-states per M-cycle, maximum M-cycles and interrupt line count.

Parameters:
- T_PER_M, 4, T-cycles per M-cycle; power of two, at least 2.
- MAX_M, 8, maximum M-cycles per opcode; power of two, at least 2.
- NUM_IRQ, 5, number of interrupt request lines; at most 8.

Ports:
- i_Clk  in  1  system clock; all state updates on rising edge.
- i_Rst  in  1  synchronous active-high reset.
- i_Enable  in  1  clock enable; no state changes while low.
- i_Reset_Cycle  in  1  microcode end-of-opcode request; next step is 0.
- i_Halt  in  1  microcode HALT request.
- i_IME  in  1  master interrupt enable.
- i_Interrupts  in  NUM_IRQ  pending interrupt flags, already masked by IE.
- o_IR_Read  out  1  high in step 0 (IR-read slot).
- o_T_Step  out  T_PER_M  one-hot T-step; all zero in step 0.
- o_M_Count  out  MAX_M  one-hot M-count; all zero in step 0.
- o_Initialize_Fetch  out  1  fetch microcode must run the current M-cycle.
- o_Halted  out  1  core sleeping in HALT.
- o_Handle_Interrupt  out  1  dispatch request, valid on an end-of-opcode step.
- o_Irq_Index  out  3  lowest-numbered pending line, valid with o_Handle_Interrupt.
- o_Wrap  out  1  one-cycle pulse when the counter overflows without i_Reset_Cycle.
- o_Fault  out  1  sticky watchdog fault (optional feature).

Behaviour:
- Step counter s has width log2(T_PER_M*MAX_M) and range 0..T_PER_M*MAX_M-1.
- Step 0 is the IR-read slot: o_IR_Read=1, o_T_Step=0, o_M_Count=0.
- For s>0: o_T_Step=onehot(s mod T_PER_M), o_M_Count=onehot(s / T_PER_M). All strobes decode combinationally from registered state.
- Reset state: s=0, initialize_fetch=1, halted=0, fault=0, o_Wrap=0. Outputs at reset: o_IR_Read=1, o_T_Step=0, o_M_Count=0, o_Initialize_Fetch=1, o_Halted=0, o_Handle_Interrupt=0, o_Irq_Index=0, o_Fault=0.
- With i_Enable low, everything holds and o_Wrap is 0.
- Counter update, only when i_Enable is high, in priority order:
  - i_Rst: reset state.
  - i_Reset_Cycle: s<=0 and initialize_fetch<=0.
  - halted and s==T_PER_M-1: s<=0 (the sleeping core loops the first M-cycle).
  - s==max with no i_Reset_Cycle: s<=0 and o_Wrap pulses for 1 cycle.
  - otherwise s<=s+1.
- Halt/wake, only when enabled; wake takes priority over halt:
  - Wake: |i_Interrupts clears halted the next cycle, regardless of i_IME.
  - Halt: i_Halt with no pending interrupt sets halted=1 and initialize_fetch=1.
  - i_Halt together with a pending interrupt leaves halted=0 (no sleep).
- o_Handle_Interrupt = i_Reset_Cycle & i_IME & |i_Interrupts & ~halted. This is combinational so the microcode can redirect on the same step.
- o_Irq_Index is the priority encoder of i_Interrupts, bit 0 highest; 0 when none pending.
- A reset asserted mid-opcode overrides everything on that edge.

Optional Feature:
- Macro: CU_WATCHDOG_EN.
- Defined: a counter wrap does not restart.
  - s is held at 0, initialize_fetch=1 and o_Fault=1.
  - o_Fault is sticky until i_Rst.
  - While faulted, i_Reset_Cycle, i_Halt and interrupts are ignored and o_Handle_Interrupt=0.
  - o_Wrap still pulses once.
- Undefined: o_Fault is tied to 0 and wrap behaves as above.

Test Plan:
- Reset, then enable for 5 cycles with defaults -> s sequence 0,1,2,3,4. o_IR_Read=1 only at s=0. At s=4: o_T_Step=4'b0001, o_M_Count=8'b00000010.
- i_Reset_Cycle at s=7 -> next s=0. o_Initialize_Fetch falls 1->0. i_Enable low on the same edge -> s stays 7.
- i_Halt at s=3 -> o_Halted=1 and o_Initialize_Fetch=1. Counter then loops 0,1,2,3,0. i_Interrupts=5'b00100 -> o_Halted=0 the next cycle.
- i_Reset_Cycle with i_IME=1 and i_Interrupts=5'b10110 -> o_Handle_Interrupt=1, o_Irq_Index=1. With i_IME=0 -> o_Handle_Interrupt=0.
- Run to s=31 with no i_Reset_Cycle -> o_Wrap=1 for one cycle, then s=0. With CU_WATCHDOG_EN -> o_Fault=1 and s stays 0 until i_Rst.
- Parameters T_PER_M=8, MAX_M=4 -> at s=9: o_T_Step=8'b00000010, o_M_Count=4'b0010. Wrap occurs after s=31.
